// File: rtl/uart_pkg.sv
// Shared definitions for the 9-bit UART receiver and transmitter:
// FSM state encoding, word size, line levels and small bit-level helpers.
package uart_pkg;

    localparam int   DATA_BITS  = 9;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    // 2-of-3 vote used to reject single-cycle glitches on the line
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Nonzero when word plus parity bit do not have an even number of ones
    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous Rx line, reset to the idle
// level so that reset release never produces a spurious falling edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall_s
);

    logic [SYNC_STAGES-1:0] stg_r;
    logic                   prev_r;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_r  <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_r <= IDLE_LEVEL;
        end else begin
            stg_r  <= {stg_r[SYNC_STAGES-2:0], rx};
            prev_r <= stg_r[SYNC_STAGES-1];
        end
    end

    assign rx_s   = stg_r[SYNC_STAGES-1];
    assign fall_s = prev_r & ~rx_s;

endmodule

// File: rtl/uart_rx_9bit.sv
// 9-bit UART receiver: start, 9 data bits LSB first, optional even parity, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of data/parity/stop.
module uart_rx_9bit
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_SPEED   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 parity,
    input  logic [3:0]           speed,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int MIN_EFF = (MIN_SPEED > 4) ? MIN_SPEED : 4;
`else
    localparam int MIN_EFF = MIN_SPEED;
`endif
    localparam logic [3:0] MIN_T    = 4'(MIN_EFF);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    uart_state_t          state_r, state_nxt_s, smp_st_s;
    logic [3:0]           cnt_r, bit_t_r, t_eff_s, half_s;
    logic [3:0]           idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_en_r, par_bit_r;
    logic                 rx_s, fall_s;
    logic                 cnt_zero_s, active_s, load_s, reload_s, dec_s;
    logic                 smp_tick_s, smp_val_s, done_s;
`ifdef UART_RX_MAJORITY_EN
    logic                 h1_r, h0_r, pend_r;
    uart_state_t          pend_st_r;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_s   (rx_s),
        .fall_s (fall_s)
    );

    assign t_eff_s    = (speed < MIN_T) ? MIN_T : speed;
    assign half_s     = t_eff_s >> 1;
    assign cnt_zero_s = (cnt_r == 4'd0);
    assign active_s   = state_r inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

    // Sample strobe: at counter zero, or one cycle later when voting over three samples
`ifdef UART_RX_MAJORITY_EN
    assign smp_tick_s = pend_r;
    assign smp_val_s  = maj3(h1_r, h0_r, rx_s);
    assign smp_st_s   = pend_st_r;
`else
    assign smp_tick_s = cnt_zero_s && (state_r inside {ST_DATA, ST_PARITY, ST_STOP});
    assign smp_val_s  = rx_s;
    assign smp_st_s   = state_r;
`endif
    assign done_s = smp_tick_s && (smp_st_s == ST_STOP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_nxt_s = ST_START;
                else        state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_zero_s) state_nxt_s = (rx_s == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
                else            state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (cnt_zero_s && (idx_r == LAST_IDX)) state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
                else                                   state_nxt_s = ST_DATA;
            end
            ST_PARITY: begin
                if (cnt_zero_s) state_nxt_s = ST_STOP;
                else            state_nxt_s = ST_PARITY;
            end
            ST_STOP: begin
                if (done_s) state_nxt_s = (smp_val_s == STOP_LEVEL) ? ST_IDLE : ST_BREAK;
                else        state_nxt_s = ST_STOP;
            end
            ST_BREAK: begin
                if (rx_s == IDLE_LEVEL) state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_BREAK;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter control decode
    always_comb begin
        load_s   = 1'b0;
        reload_s = 1'b0;
        dec_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            load_s = fall_s;
        end else if (active_s) begin
            reload_s = cnt_zero_s;
            dec_s    = ~cnt_zero_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Bit timing, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= 4'd0;
            bit_t_r      <= 4'd0;
            par_en_r     <= 1'b0;
            par_bit_r    <= 1'b0;
            idx_r        <= 4'd0;
            shift_r      <= '0;
            data         <= '0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (load_s) begin
                cnt_r    <= half_s - 4'd1;
                bit_t_r  <= t_eff_s;
                par_en_r <= parity;
            end else if (reload_s) begin
                cnt_r <= bit_t_r - 4'd1;
            end else if (dec_s) begin
                cnt_r <= cnt_r - 4'd1;
            end

            if ((state_r == ST_START) && cnt_zero_s) begin
                idx_r <= 4'd0;
            end else if ((state_r == ST_DATA) && cnt_zero_s) begin
                idx_r <= idx_r + 4'd1;
            end

            // LSB arrives first, so after nine shifts bit 0 sits at position 0
            if (smp_tick_s && (smp_st_s == ST_DATA)) begin
                shift_r <= {smp_val_s, shift_r[DATA_BITS-1:1]};
            end
            if (smp_tick_s && (smp_st_s == ST_PARITY)) begin
                par_bit_r <= smp_val_s;
            end

            valid <= done_s;
            if (done_s) begin
                data         <= shift_r;
                parity_error <= par_en_r & even_parity_err(shift_r, par_bit_r);
                frame_error  <= (smp_val_s != STOP_LEVEL);
            end

            busy <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Capture the two samples preceding the vote; the third is rx_s on the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_r      <= 1'b1;
            h0_r      <= 1'b1;
            pend_r    <= 1'b0;
            pend_st_r <= ST_IDLE;
        end else begin
            if (cnt_r == 4'd1) h1_r <= rx_s;
            if (cnt_zero_s)    h0_r <= rx_s;
            pend_r    <= cnt_zero_s && (state_r inside {ST_DATA, ST_PARITY, ST_STOP});
            pend_st_r <= state_r;
        end
    end
`endif

endmodule

// File: doc/uart_rx_9bit.md
Name: uart_rx_9bit

Overview:
- Serial receiver paired with the 9-bit UART transmitter; consumes its Tx line and recovers 9-bit words.
- Frame format: start bit (0), 9 data bits LSB first, optional even-parity bit, stop bit (1).
- Bit time is programmable in clock cycles via Speed. Provides a one-cycle Valid strobe plus parity and framing error flags to downstream logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the Rx input synchronizer (minimum 2).
- MIN_SPEED, 2, smallest legal bit time in clocks; smaller Speed values are clamped to it.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Rx  input  1  serial line, idle high; asynchronous to Clock.
- Parity  input  1  1 = parity bit expected after data bit 8; 0 = no parity bit.
- Speed  input  4  bit time in Clock cycles (0..15).
- Data  output  9  last received word; holds until the next frame completes.
- Valid  output  1  single-cycle pulse when Data, ParityError and FrameError update.
- ParityError  output  1  qualified by Valid; received parity mismatched even parity over Data.
- FrameError  output  1  qualified by Valid; sampled stop bit was 0.
- Busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values: Data=0, Valid=0, ParityError=0, FrameError=0, Busy=0, FSM=IDLE. Synchronizer flops reset to 1.
- Effective bit time T = max(Speed, MIN_SPEED), with half H = T>>1.
- T, H and Parity are latched on start detection. Input changes mid-frame have no effect until the next frame.
- Synchronized line rx_s lags Rx by SYNC_STAGES cycles. All sampling below uses rx_s.
- IDLE: on falling edge of rx_s (previous 1, current 0), load counter=H-1, set Busy=1, go to START.
- START: on counter==0, sample rx_s.
  - If rx_s=1 (false start): Busy=0, go to IDLE, no Valid.
  - Otherwise: counter=T-1, bit index=0, go to DATA.
- DATA: on counter==0, shift rx_s into bit[index] and reload counter=T-1.
  - After index 8: go to PARITY if latched Parity=1, else go to STOP.
- PARITY: on counter==0, sample and store the parity bit, reload counter=T-1, go to STOP.
- STOP: on counter==0, sample the stop bit. On the next clock edge:
  - Data = shifted word; Valid=1 for exactly one cycle.
  - ParityError = (Parity latched) and (XOR of 9 data bits XOR parity bit != 0); 0 when parity is disabled.
  - FrameError = (stop sample == 0).
  - Go to IDLE if the stop sample was 1, else go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering a frame. Busy stays 1 in BREAK.
- Counter is 4 bits and decrements from T-1 to 0 with no wrap-around beyond reload.
- Reset asserted mid-frame: immediate return to reset values; the partial word is discarded.
- Start edge arriving in the same cycle as the Valid pulse is detected normally (IDLE entered that cycle). Back-to-back frames are supported.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each data, parity and stop sample is the 2-of-3 majority of rx_s at counter values 1, 0 and the cycle after 0 (sample resolved one cycle late). MIN_SPEED is effectively forced to 4. The start bit is still checked at H.
- Undefined: single sample at counter==0 as described above.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=9, stop and idle level constants. The transmitter reuses the same package.
- Sub-module uart_rx_sync: parameterized SYNC_STAGES synchronizer with reset-to-1. Exports rx_s and a falling-edge strobe.
- Bit-timing counter and FSM stay in the top module.

Test Plan:
- Speed=2, Parity=1, Tx frame of 9'b100101110 (parity bit 1) -> single Valid pulse, Data=9'h12E, ParityError=0, FrameError=0.
- Speed=3, Parity=0, frame of 9'b101010110 -> Valid, Data=9'h156, no errors. Valid occurs ~(1+9+1)*3 cycles after the start edge plus SYNC_STAGES.
- Speed=8, Rx low for 2 cycles then high -> false start; Busy pulses, then returns to 0; no Valid.
- Speed=4, Parity=1, Data 9'h0FF sent with parity bit inverted -> Valid with ParityError=1, Data=9'h0FF.
- Speed=4, stop bit driven 0 and held low for 20 cycles -> Valid with FrameError=1; Busy stays high until Rx returns high; no second frame reported.
- Reset asserted during data bit 4 -> all outputs 0 within the same cycle; a following clean frame 9'h1A5 at Speed=5 is received correctly.
